// File: rtl/apb_rr_arbiter.sv
// Two-requester APB arbiter: round-robin grant per transfer,
// SETUP/ACCESS sequencing and an ACCESS-phase hang timeout.
module apb_rr_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  S0_PSEL,
  input  logic                  S0_PENABLE,
  input  logic                  S0_PWRITE,
  input  logic [ADDR_WIDTH-1:0] S0_PADDR,
  input  logic [DATA_WIDTH-1:0] S0_PWDATA,
  output logic                  S0_PREADY,
  output logic                  S0_PSLVERR,
  output logic [DATA_WIDTH-1:0] S0_PRDATA,
  input  logic                  S1_PSEL,
  input  logic                  S1_PENABLE,
  input  logic                  S1_PWRITE,
  input  logic [ADDR_WIDTH-1:0] S1_PADDR,
  input  logic [DATA_WIDTH-1:0] S1_PWDATA,
  output logic                  S1_PREADY,
  output logic                  S1_PSLVERR,
  output logic [DATA_WIDTH-1:0] S1_PRDATA,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  TIMEOUT_EV
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] TO_VAL  = CW'(TIMEOUT);
  localparam bit TO_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_e;

  state_e        state_q, state_d;
  logic          grant_q, grant_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic req0, req1;
  logic acc, timeout_hit, done, err;
  logic unused_penable;

  // PENABLE from requesters carries no information for arbitration
  assign unused_penable = S0_PENABLE ^ S1_PENABLE;

  assign req0 = S0_PSEL;
  assign req1 = S1_PSEL;
  assign acc  = (state_q == ACCESS);

  assign timeout_hit = TO_EN && acc && (cnt_q == TO_VAL) && !PREADY;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          grant_d = (req0 && req1) ? ~last_q : req1;
          last_d  = grant_d;
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = '0;
      end
      ACCESS: begin
        if (PREADY || timeout_hit) begin
          state_d = IDLE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    PSEL    = (state_q != IDLE);
    PENABLE = acc;
    PWRITE  = 1'b0;
    PADDR   = '0;
    PWDATA  = '0;
    if (state_q != IDLE) begin
      PWRITE = grant_q ? S1_PWRITE : S0_PWRITE;
      PADDR  = grant_q ? S1_PADDR  : S0_PADDR;
      PWDATA = grant_q ? S1_PWDATA : S0_PWDATA;
    end
  end

  // timeout forces an error completion with zeroed read data
  assign done = acc && (PREADY || timeout_hit);
  assign err  = done && (PSLVERR || timeout_hit);

  assign S0_PREADY  = done && !grant_q;
  assign S0_PSLVERR = err && !grant_q;
  assign S0_PRDATA  = (acc && !grant_q && !timeout_hit) ? PRDATA : '0;

  assign S1_PREADY  = done && grant_q;
  assign S1_PSLVERR = err && grant_q;
  assign S1_PRDATA  = (acc && grant_q && !timeout_hit) ? PRDATA : '0;

  assign TIMEOUT_EV = timeout_hit;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Directed bench for apb_rr_arbiter: arbitration, wait states,
// timeout (TIMEOUT=4 and disabled) and asynchronous reset.
module tb_apb_rr_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          HCLK, HRESET;
  logic          S0_PSEL, S0_PENABLE, S0_PWRITE;
  logic [AW-1:0] S0_PADDR;
  logic [DW-1:0] S0_PWDATA;
  logic          S1_PSEL, S1_PENABLE, S1_PWRITE;
  logic [AW-1:0] S1_PADDR;
  logic [DW-1:0] S1_PWDATA;
  logic          PREADY, PSLVERR;
  logic [DW-1:0] PRDATA;

  logic          S0_PREADY, S0_PSLVERR, S1_PREADY, S1_PSLVERR;
  logic [DW-1:0] S0_PRDATA, S1_PRDATA;
  logic          PSEL, PENABLE, PWRITE, TIMEOUT_EV;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;

  logic          z_S0_PREADY, z_S0_PSLVERR, z_S1_PREADY, z_S1_PSLVERR;
  logic [DW-1:0] z_S0_PRDATA, z_S1_PRDATA;
  logic          z_PSEL, z_PENABLE, z_PWRITE, z_TIMEOUT_EV;
  logic [AW-1:0] z_PADDR;
  logic [DW-1:0] z_PWDATA;

  int n_chk  = 0;
  int n_pass = 0;

  apb_rr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(4)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .S0_PSEL(S0_PSEL), .S0_PENABLE(S0_PENABLE), .S0_PWRITE(S0_PWRITE),
    .S0_PADDR(S0_PADDR), .S0_PWDATA(S0_PWDATA),
    .S0_PREADY(S0_PREADY), .S0_PSLVERR(S0_PSLVERR), .S0_PRDATA(S0_PRDATA),
    .S1_PSEL(S1_PSEL), .S1_PENABLE(S1_PENABLE), .S1_PWRITE(S1_PWRITE),
    .S1_PADDR(S1_PADDR), .S1_PWDATA(S1_PWDATA),
    .S1_PREADY(S1_PREADY), .S1_PSLVERR(S1_PSLVERR), .S1_PRDATA(S1_PRDATA),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA),
    .TIMEOUT_EV(TIMEOUT_EV)
  );

  apb_rr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(0)) dut0 (
    .HCLK(HCLK), .HRESET(HRESET),
    .S0_PSEL(S0_PSEL), .S0_PENABLE(S0_PENABLE), .S0_PWRITE(S0_PWRITE),
    .S0_PADDR(S0_PADDR), .S0_PWDATA(S0_PWDATA),
    .S0_PREADY(z_S0_PREADY), .S0_PSLVERR(z_S0_PSLVERR),
    .S0_PRDATA(z_S0_PRDATA),
    .S1_PSEL(S1_PSEL), .S1_PENABLE(S1_PENABLE), .S1_PWRITE(S1_PWRITE),
    .S1_PADDR(S1_PADDR), .S1_PWDATA(S1_PWDATA),
    .S1_PREADY(z_S1_PREADY), .S1_PSLVERR(z_S1_PSLVERR),
    .S1_PRDATA(z_S1_PRDATA),
    .PSEL(z_PSEL), .PENABLE(z_PENABLE), .PWRITE(z_PWRITE),
    .PADDR(z_PADDR), .PWDATA(z_PWDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA),
    .TIMEOUT_EV(z_TIMEOUT_EV)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clr();
    S0_PSEL = 0; S0_PENABLE = 0; S0_PWRITE = 0; S0_PADDR = '0; S0_PWDATA = '0;
    S1_PSEL = 0; S1_PENABLE = 0; S1_PWRITE = 0; S1_PADDR = '0; S1_PWDATA = '0;
    PREADY = 0; PSLVERR = 0; PRDATA = '0;
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic do_reset();
    HRESET = 1'b1;
    clr();
    step();
    HRESET = 1'b0;
  endtask

  logic bad;

  initial begin
    clr();
    HRESET = 1'b1;
    S0_PSEL = 1; S1_PSEL = 1; PREADY = 1; S0_PADDR = 32'h1234;
    #2;
    chk("rst_psel", PSEL, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_s0rdy", S0_PREADY, 0);
    step();
    HRESET = 1'b0;
    clr();

    // single read by S0
    S0_PSEL = 1; S0_PADDR = 32'h4000_1000;
    #1;
    chk("t1_idle_psel", PSEL, 0);
    step();
    PREADY = 1; PRDATA = 32'hDEAD_BEEF;
    #1;
    chk("t1_setup_psel", PSEL, 1);
    chk("t1_setup_pen", PENABLE, 0);
    chk("t1_setup_addr", PADDR, 32'h4000_1000);
    S0_PENABLE = 1;
    step();
    #1;
    chk("t1_acc_pen", PENABLE, 1);
    chk("t1_s0rdy", S0_PREADY, 1);
    chk("t1_s0rdata", S0_PRDATA, 32'hDEAD_BEEF);
    chk("t1_s1rdy", S1_PREADY, 0);
    chk("t1_s1rdata", S1_PRDATA, 0);
    S0_PSEL = 0; S0_PENABLE = 0;
    step();
    #1;
    chk("t1_idle2_psel", PSEL, 0);

    // both write from reset
    do_reset();
    S0_PSEL = 1; S0_PWRITE = 1; S0_PADDR = 32'h10; S0_PWDATA = 32'h11;
    S1_PSEL = 1; S1_PWRITE = 1; S1_PADDR = 32'h20; S1_PWDATA = 32'h22;
    PREADY = 1;
    step();
    #1;
    chk("t2_a_addr", PADDR, 32'h10);
    chk("t2_a_wdata", PWDATA, 32'h11);
    chk("t2_a_write", PWRITE, 1);
    step();
    #1;
    chk("t2_a_s0rdy", S0_PREADY, 1);
    chk("t2_a_s1rdy", S1_PREADY, 0);
    S0_PSEL = 0;
    step();
    #1;
    chk("t2_gap_psel", PSEL, 0);
    chk("t2_gap_s0rdy", S0_PREADY, 0);
    step();
    #1;
    chk("t2_b_addr", PADDR, 32'h20);
    chk("t2_b_wdata", PWDATA, 32'h22);
    step();
    #1;
    chk("t2_b_s1rdy", S1_PREADY, 1);
    chk("t2_b_s0rdy", S0_PREADY, 0);
    S1_PSEL = 0;
    step();

    // continuous requests alternate
    S0_PSEL = 1; S0_PADDR = 32'h100;
    S1_PSEL = 1; S1_PADDR = 32'h200;
    PREADY = 1;
    for (int k = 0; k < 8; k++) begin
      step();
      step();
      #1;
      chk("t3_addr", PADDR, (k % 2) ? 32'h200 : 32'h100);
      chk("t3_s0rdy", S0_PREADY, (k % 2) ? 0 : 1);
      step();
    end

    // S1 with three wait states then error
    do_reset();
    S1_PSEL = 1; S1_PADDR = 32'h300;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      #1;
      chk("t4_wait_rdy", S1_PREADY, 0);
    end
    step();
    PREADY = 1; PSLVERR = 1;
    #1;
    chk("t4_rdy", S1_PREADY, 1);
    chk("t4_err", S1_PSLVERR, 1);
    chk("t4_to", TIMEOUT_EV, 0);
    S1_PSEL = 0; PREADY = 0; PSLVERR = 0;
    step();

    // timeout after five ACCESS cycles; disabled instance keeps waiting
    do_reset();
    S0_PSEL = 1; S0_PADDR = 32'h500; PRDATA = 32'hCAFE;
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      #1;
      chk("t5_wait_to", TIMEOUT_EV, 0);
      chk("t5_wait_rdy", S0_PREADY, 0);
    end
    step();
    #1;
    chk("t5_to", TIMEOUT_EV, 1);
    chk("t5_rdy", S0_PREADY, 1);
    chk("t5_err", S0_PSLVERR, 1);
    chk("t5_rdata", S0_PRDATA, 0);
    S0_PSEL = 0;
    step();
    #1;
    chk("t5_psel_drop", PSEL, 0);
    chk("t5_z_pen", z_PENABLE, 1);
    bad = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step();
      #1;
      if (z_TIMEOUT_EV || z_S0_PREADY || !z_PENABLE) bad = 1'b1;
    end
    chk("t5_no_timeout", bad, 0);

    // reset during ACCESS
    do_reset();
    S1_PSEL = 1; S1_PADDR = 32'h300;
    step();
    step();
    #1;
    chk("t6_acc_psel", PSEL, 1);
    chk("t6_acc_addr", PADDR, 32'h300);
    PREADY = 1; PRDATA = 32'h55;
    HRESET = 1'b1;
    #1;
    chk("t6_rst_psel", PSEL, 0);
    chk("t6_rst_pen", PENABLE, 0);
    chk("t6_rst_s1rdy", S1_PREADY, 0);
    chk("t6_rst_s1rdata", S1_PRDATA, 0);
    HRESET = 1'b0;
    S0_PSEL = 1; S0_PADDR = 32'h400;
    step();
    #1;
    chk("t6_first_addr", PADDR, 32'h400);
    step();
    #1;
    chk("t6_s0rdy", S0_PREADY, 1);
    chk("t6_s1rdy", S1_PREADY, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
